// File: rtl/dmem_responder.sv
// Single-port data memory responder with a fixed per-access wait time.
// One request is outstanding at a time: IDLE accepts, WAIT counts down the
// latency, RESP holds the result until the initiator takes it.
module dmem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   // Contents are intentionally left unreset.
   logic [31:0] mem [0:(1 << ADDR_W) - 1];

   logic [ADDR_W-1:0] widx;
   logic              addr_err;
   logic              access;
   logic              do_write;

   assign widx     = addr_q[ADDR_W+1:2];
   assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);
   assign access   = (state_q == WAIT) && (cnt_q == 4'd0);
   assign do_write = access && we_q && !addr_err;

   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // Next-state: latch the request in IDLE, count down in WAIT, hold in RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = CNT_INIT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               err_d   = addr_err;
               // Stores and faulting requests return zero data.
               rdata_d = (!addr_err && !we_q) ? mem[widx] : 32'd0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and response registers; reset drops any pending access or response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Byte-masked store on the access edge; reset forces IDLE so no write can slip through.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed checks on a LATENCY=3 instance,
// randomised traffic with backpressure on LATENCY=1 and LATENCY=15 instances.
module tb_dmem_responder;

   localparam int LAT [3] = '{3, 1, 15};

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid  [3];
   logic        req_ready  [3];
   logic        req_we     [3];
   logic [31:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic [3:0]  req_be     [3];
   logic        resp_valid [3];
   logic        resp_ready [3];
   logic [31:0] resp_rdata [3];
   logic        resp_err   [3];
   logic        busy       [3];

   int          n_checks;
   int          n_fail;
   int          hs_cnt [3];
   exp_t        sb [$];
   logic [31:0] model [int];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_responder #(
         .ADDR_W (10),
         .LATENCY((g == 0) ? 3 : ((g == 1) ? 1 : 15))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_be    (req_be[g]),
         .resp_valid(resp_valid[g]),
         .resp_ready(resp_ready[g]),
         .resp_rdata(resp_rdata[g]),
         .resp_err  (resp_err[g]),
         .busy      (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count completed response handshakes per instance.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (resp_valid[k] === 1'b1 && resp_ready[k] === 1'b1) hs_cnt[k]++;
      end
   end

   initial begin
      #800000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Drive one request and wait for acceptance; optionally record its expectation.
   task automatic issue(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input bit push);
      exp_t        e;
      int          w;
      int          n;
      logic [31:0] nw;
      e.err   = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
      e.rdata = 32'd0;
      if (!e.err && push) begin
         w = int'(addr[11:2]);
         if (we) begin
            nw = model.exists(w) ? model[w] : 32'd0;
            for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wdata[8*b +: 8];
            if (be != 4'd0) model[w] = nw;
         end else begin
            e.rdata = model[w];
         end
      end
      if (push) sb.push_back(e);
      @(negedge clk);
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      req_be[k]    = be;
      n = 0;
      while (req_ready[k] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_before_accept", 32'(req_ready[k]), 32'd1);
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      // Scramble inputs while the access is outstanding.
      req_we[k]    = ~we;
      req_addr[k]  = $urandom;
      req_wdata[k] = $urandom;
      req_be[k]    = 4'($urandom);
      check("busy_after_accept", 32'(busy[k]), 32'd1);
   endtask

   task automatic wait_resp(input int k);
      int lat;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (resp_valid[k] !== 1'b1 && lat < 40);
      check("resp_latency", 32'(lat), 32'(LAT[k]));
   endtask

   task automatic finish_resp(input int k, input int stalls);
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < stalls; i++) begin
         @(negedge clk);
         check("stall_resp_valid", 32'(resp_valid[k]), 32'd1);
         check("stall_rdata", resp_rdata[k], e.rdata);
         check("stall_busy", 32'(busy[k]), 32'd1);
      end
      @(negedge clk);
      resp_ready[k] = 1'b1;
      check("resp_rdata", resp_rdata[k], e.rdata);
      check("resp_err", 32'(resp_err[k]), 32'(e.err));
      @(posedge clk);
      #1;
      resp_ready[k] = 1'b0;
      check("idle_busy", 32'(busy[k]), 32'd0);
      check("idle_req_ready", 32'(req_ready[k]), 32'd1);
      check("idle_resp_valid", 32'(resp_valid[k]), 32'd0);
   endtask

   task automatic transact(input int k, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int stalls);
      issue(k, we, addr, wdata, be, 1'b1);
      wait_resp(k);
      finish_resp(k, stalls);
   endtask

   task automatic check_reset_outputs(input int k, input string tag);
      check({tag, "_resp_valid"}, 32'(resp_valid[k]), 32'd0);
      check({tag, "_resp_rdata"}, resp_rdata[k], 32'd0);
      check({tag, "_resp_err"}, 32'(resp_err[k]), 32'd0);
      check({tag, "_busy"}, 32'(busy[k]), 32'd0);
   endtask

   task automatic random_phase(input int k, input int n_ops);
      int          hs0;
      int          n_acc;
      logic [31:0] addr;
      int          sel;
      model.delete();
      hs0   = hs_cnt[k];
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         transact(k, 1'b1, 32'h40 + 32'(4 * i), $urandom, 4'hF, 0);
         n_acc++;
      end
      for (int i = 0; i < n_ops; i++) begin
         sel  = $urandom_range(0, 9);
         addr = 32'h40 + 32'(4 * $urandom_range(0, 7));
         if (sel == 0) addr = addr + 32'($urandom_range(1, 3));
         else if (sel == 1) addr = addr | 32'h0000_1000;
         transact(k, 1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 3));
         n_acc++;
      end
      check("one_resp_per_request", 32'(hs_cnt[k] - hs0), 32'(n_acc));
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int hs0;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      for (int k = 0; k < 3; k++) begin
         hs_cnt[k]     = 0;
         req_valid[k]  = 1'b0;
         req_we[k]     = 1'b0;
         req_addr[k]   = 32'd0;
         req_wdata[k]  = 32'd0;
         req_be[k]     = 4'd0;
         resp_ready[k] = 1'b0;
      end
      #7;
      for (int k = 0; k < 3; k++) check_reset_outputs(k, "reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) check("reset_req_ready", 32'(req_ready[k]), 32'd1);

      // Full store, load back, byte-masked store, load back.
      transact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
      transact(0, 1'b1, 32'h10, 32'h12345678, 4'b0101, 1);
      transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
      // Misaligned and out-of-range requests, including a store that aliases word 0x10.
      transact(0, 1'b0, 32'h13, 32'h0, 4'h0, 0);
      transact(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 2);
      transact(0, 1'b1, 32'h0000_1010, 32'hAAAAAAAA, 4'hF, 0);
      transact(0, 1'b1, 32'h10, 32'h55555555, 4'h0, 0);
      // Load under five cycles of backpressure.
      transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);

      // Reset during WAIT discards the pending store.
      transact(0, 1'b1, 32'h20, 32'h11111111, 4'hF, 0);
      issue(0, 1'b1, 32'h20, 32'h22222222, 4'hF, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs(0, "rst_wait");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      transact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

      // Reset during RESP drops the response without a handshake.
      hs0 = hs_cnt[0];
      issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
      wait_resp(0);
      rst = 1'b1;
      #1;
      check_reset_outputs(0, "rst_resp");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_resp_no_handshake", 32'(hs_cnt[0] - hs0), 32'd0);
      check("rst_resp_req_ready", 32'(req_ready[0]), 32'd1);

      random_phase(1, 60);
      random_phase(2, 60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving word-address width (memory depth 2^ADDR_W words of 32 bits).
REQ-002 SHALL have parameter LATENCY, default 3, giving wait cycles per access; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  store byte enables; bit i selects wdata[8i+7:8i].
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  initiator accepts response.
REQ-013 SHALL have port resp_rdata  output  32  load data.
REQ-014 SHALL have port resp_err  output  1  request was misaligned or out of range.
REQ-015 SHALL have port busy  output  1  a request is outstanding; usable as pipeline stall.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; busy=1 exactly when state is not IDLE.
REQ-018 In IDLE, when req_valid=1 at a rising edge, SHALL latch we, addr, wdata, be, enter WAIT, and load a 4-bit counter with LATENCY-1.
REQ-019 In WAIT, SHALL decrement the counter each edge; at the edge where the counter is 0, SHALL perform the access and enter RESP.
REQ-020 A request accepted at edge T0 SHALL produce resp_valid=1 after edge T0+LATENCY.
REQ-021 In RESP, SHALL hold resp_valid, resp_rdata and resp_err stable until an edge with resp_ready=1, then return to IDLE.
REQ-022 A new request SHALL NOT be accepted on the edge that completes a response; the earliest next acceptance is the following edge.
REQ-023 An error SHALL be flagged when req_addr[1:0] is not 0 or req_addr[31:ADDR_W+2] is not 0.
REQ-024 An erroring request SHALL leave memory unchanged and return resp_rdata=0, resp_err=1.
REQ-025 A valid store SHALL write only the enabled bytes of word req_addr[ADDR_W+1:2] and return resp_rdata=0, resp_err=0.
REQ-026 A store with req_be=0 SHALL complete normally without modifying memory.
REQ-027 A valid load SHALL return the full addressed word with resp_err=0; req_be is ignored for loads.
REQ-028 Request inputs SHALL be ignored outside IDLE; changing them during WAIT or RESP SHALL NOT affect the outstanding access.
REQ-029 Memory array contents SHALL NOT be reset and SHALL be undefined until written.

Reset
REQ-030 On rst=1, SHALL immediately enter IDLE with resp_valid=0, resp_rdata=0, resp_err=0, busy=0, counter=0; req_ready=1 once rst is released.
REQ-031 Reset asserted during WAIT SHALL discard the pending access so that no memory write occurs.
REQ-032 Reset asserted during RESP SHALL drop the response without completing the handshake.

Verification
REQ-033 Store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 with LATENCY=3 -> each resp_valid rises 3 edges after acceptance; load returns 0xDEADBEEF, resp_err=0.
REQ-034 Store 0x12345678 be 4'b0101 over word 0xDEADBEEF at 0x10, then load -> 0xDE34BE78.
REQ-035 Load 0x13 and load 0x00001000 (ADDR_W=10) -> resp_err=1, resp_rdata=0; a following load of 0x10 returns its prior value unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and busy stay stable; on release, IDLE is entered and req_ready=1 on the next cycle.
REQ-037 Assert rst during WAIT of a store to 0x20 whose word holds 0x11111111 -> outputs reset at once; a later load of 0x20 returns 0x11111111.
REQ-038 Random requests with random resp_ready backpressure across LATENCY 1 and 15, checked against a reference memory model -> every read data value matches the model, and there is exactly one response per accepted request.
